// File: rtl/adder_result_accum.sv
// Batch accumulator for the 4-bit ripple adder results: sums BATCH {cout,sum} operands
// and presents the 8-bit total with a sticky overflow flag. Optional macro: ADDER_ACCUM_SATURATE_EN.
module adder_result_accum #(
  parameter int BATCH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_sum,
  input  logic       in_cout,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       clr,
  output logic [7:0] out_data,
  output logic       out_ovf,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] level
);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  localparam logic [4:0] LAST_LEVEL = 5'(BATCH - 1);

  state_t     state_r;
  state_t     state_nx_s;
  logic [7:0] acc_r;
  logic [7:0] acc_nx_s;
  logic       ovf_r;
  logic       ovf_nx_s;
  logic [4:0] level_r;
  logic [4:0] level_nx_s;
  logic       in_ready_r;
  logic       out_valid_r;
  logic [8:0] sum_s;
  logic       accept_s;
  logic       handoff_s;

  // Carry out of the 9-bit sum is the overflow indication for this accept.
  assign sum_s     = {1'b0, acc_r} + {4'b0000, in_cout, in_sum};
  assign accept_s  = in_valid & in_ready_r;
  assign handoff_s = out_valid_r & out_ready;

  // Next-state and datapath update; clr overrides any accept or handoff.
  always_comb begin
    state_nx_s = state_r;
    acc_nx_s   = acc_r;
    ovf_nx_s   = ovf_r;
    level_nx_s = level_r;
    if (clr) begin
      state_nx_s = ST_COLLECT;
      acc_nx_s   = 8'h00;
      ovf_nx_s   = 1'b0;
      level_nx_s = 5'd0;
    end else begin
      case (state_r)
        ST_COLLECT: begin
          if (accept_s) begin
`ifdef ADDER_ACCUM_SATURATE_EN
            acc_nx_s = (ovf_r | sum_s[8]) ? 8'hFF : sum_s[7:0];
`else
            acc_nx_s = sum_s[7:0];
`endif
            ovf_nx_s   = ovf_r | sum_s[8];
            level_nx_s = level_r + 5'd1;
            if (level_r == LAST_LEVEL) begin
              state_nx_s = ST_PRESENT;
            end else begin
              state_nx_s = ST_COLLECT;
            end
          end else begin
            state_nx_s = ST_COLLECT;
          end
        end
        ST_PRESENT: begin
          if (handoff_s) begin
            state_nx_s = ST_COLLECT;
            acc_nx_s   = 8'h00;
            ovf_nx_s   = 1'b0;
            level_nx_s = 5'd0;
          end else begin
            state_nx_s = ST_PRESENT;
          end
        end
        default: begin
          state_nx_s = ST_COLLECT;
          acc_nx_s   = 8'h00;
          ovf_nx_s   = 1'b0;
          level_nx_s = 5'd0;
        end
      endcase
    end
  end

  // State, datapath and handshake flops; handshake outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_COLLECT;
      acc_r       <= 8'h00;
      ovf_r       <= 1'b0;
      level_r     <= 5'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      acc_r       <= acc_nx_s;
      ovf_r       <= ovf_nx_s;
      level_r     <= level_nx_s;
      in_ready_r  <= (state_nx_s == ST_COLLECT);
      out_valid_r <= (state_nx_s == ST_PRESENT);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = acc_r;
  assign out_ovf   = ovf_r;
  assign level     = level_r;

endmodule

// File: tb/tb_adder_result_accum.sv
// Table-driven bench: three instances (BATCH = 8, 16, 1) share stimulus; a selector routes
// in_valid to one instance and muxes that instance's outputs for checking.
module tb_adder_result_accum;

  typedef struct {
    int         sel;
    logic [3:0] sum;
    logic       cout;
    logic       valid;
    logic       ordy;
    logic       clr;
    logic       exp_ir;
    logic       exp_ov;
    logic [7:0] exp_data;
    logic       exp_ovf;
    logic [4:0] exp_level;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_sum;
  logic       in_cout;
  logic       in_valid;
  logic       clr;
  logic       out_ready;
  int         sel;

  logic       v0, v1, v2;
  logic       ir0, ir1, ir2, ov0, ov1, ov2, f0, f1, f2;
  logic [7:0] d0, d1, d2;
  logic [4:0] l0, l1, l2;

  logic       o_ir, o_ov, o_ovf;
  logic [7:0] o_data;
  logic [4:0] o_level;

  int pass_cnt = 0;
  int total_cnt = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  assign v0 = in_valid & (sel == 0);
  assign v1 = in_valid & (sel == 1);
  assign v2 = in_valid & (sel == 2);

  adder_result_accum #(.BATCH(8)) dut8 (
    .clk(clk), .rst(rst), .in_sum(in_sum), .in_cout(in_cout), .in_valid(v0), .in_ready(ir0),
    .clr(clr), .out_data(d0), .out_ovf(f0), .out_valid(ov0), .out_ready(out_ready), .level(l0));
  adder_result_accum #(.BATCH(16)) dut16 (
    .clk(clk), .rst(rst), .in_sum(in_sum), .in_cout(in_cout), .in_valid(v1), .in_ready(ir1),
    .clr(clr), .out_data(d1), .out_ovf(f1), .out_valid(ov1), .out_ready(out_ready), .level(l1));
  adder_result_accum #(.BATCH(1)) dut1 (
    .clk(clk), .rst(rst), .in_sum(in_sum), .in_cout(in_cout), .in_valid(v2), .in_ready(ir2),
    .clr(clr), .out_data(d2), .out_ovf(f2), .out_valid(ov2), .out_ready(out_ready), .level(l2));

  always_comb begin
    o_ir = ir0; o_ov = ov0; o_data = d0; o_ovf = f0; o_level = l0;
    case (sel)
      1:       begin o_ir = ir1; o_ov = ov1; o_data = d1; o_ovf = f1; o_level = l1; end
      2:       begin o_ir = ir2; o_ov = ov2; o_data = d2; o_ovf = f2; o_level = l2; end
      default: begin o_ir = ir0; o_ov = ov0; o_data = d0; o_ovf = f0; o_level = l0; end
    endcase
  end

  task automatic add(input int s, input int val, input bit v, input bit ordy, input bit c,
                     input bit ir, input bit ov, input int d, input bit f, input int lvl);
    vec_t t;
    t.sel = s; t.sum = 4'(val); t.cout = 1'(val >> 4); t.valid = v; t.ordy = ordy; t.clr = c;
    t.exp_ir = ir; t.exp_ov = ov; t.exp_data = 8'(d); t.exp_ovf = f; t.exp_level = 5'(lvl);
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic ir, input logic ov, input logic [7:0] d,
                       input logic f, input logic [4:0] lvl);
    total_cnt++;
    if (o_ir === ir && o_ov === ov && o_data === d && o_ovf === f && o_level === lvl) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s sel%0d: got ir=%b ov=%b data=%0d ovf=%b lvl=%0d, want ir=%b ov=%b data=%0d ovf=%b lvl=%0d",
               name, sel, o_ir, o_ov, o_data, o_ovf, o_level, ir, ov, d, f, lvl);
    end
  endtask

  initial begin
    int d;
    bit f;
    // BATCH=8: basic batch, handoff bubble
    for (int k = 1; k <= 8; k++) add(0, 3, 1, 1, 0, k < 8, k == 8, 3 * k, 0, k);
    add(0, 3, 1, 1, 0, 1, 0, 0, 0, 0);
    // back-pressure: batch of 2s, then 5 stalled cycles with in_valid high
    for (int k = 1; k <= 8; k++) add(0, 2, 1, 0, 0, k < 8, k == 8, 2 * k, 0, k);
    for (int k = 0; k < 5; k++) add(0, 9, 1, 0, 0, 0, 1, 16, 0, 8);
    add(0, 9, 1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 9, 0, 1, 0, 1, 0, 0, 0, 0);
    // clear mid-batch with a simultaneous accept
    add(0, 2, 1, 1, 0, 1, 0, 2, 0, 1);
    add(0, 3, 1, 1, 0, 1, 0, 5, 0, 2);
    add(0, 5, 1, 1, 0, 1, 0, 10, 0, 3);
    add(0, 5, 1, 1, 1, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) add(0, 1, 1, 0, 0, k < 8, k == 8, k, 0, k);
    // clear discards a pending PRESENT output
    add(0, 1, 1, 0, 1, 1, 0, 0, 0, 0);
    // BATCH=16 overflow with value 31
    for (int k = 1; k <= 16; k++) begin
      f = (31 * k) > 255;
      d = (31 * k) % 256;
`ifdef ADDER_ACCUM_SATURATE_EN
      if (f) d = 255;
`endif
      add(1, 31, 1, 1, 0, k < 16, k == 16, d, f, k);
    end
    add(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    // BATCH=1 skid behaviour
    add(2, 7, 1, 1, 0, 0, 1, 7, 0, 1);
    add(2, 31, 1, 1, 0, 1, 0, 0, 0, 0);
    add(2, 31, 1, 1, 0, 0, 1, 31, 0, 1);
    add(2, 7, 1, 1, 0, 1, 0, 0, 0, 0);
    // clr together with handoff ends in a cleared COLLECT
    add(2, 7, 1, 0, 0, 0, 1, 7, 0, 1);
    add(2, 0, 0, 1, 1, 1, 0, 0, 0, 0);

    // Reset with in_valid asserted: nothing may be accepted
    sel = 0; rst = 1'b1; in_valid = 1'b1; in_sum = 4'd5; in_cout = 1'b0;
    clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 1'b1, 1'b0, 8'd0, 1'b0, 5'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", 1'b1, 1'b0, 8'd0, 1'b0, 5'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      sel = vecs[i].sel; in_sum = vecs[i].sum; in_cout = vecs[i].cout;
      in_valid = vecs[i].valid; out_ready = vecs[i].ordy; clr = vecs[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("row%0d", i), vecs[i].exp_ir, vecs[i].exp_ov, vecs[i].exp_data,
            vecs[i].exp_ovf, vecs[i].exp_level);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
